// File: rtl/tinyrv_mc.sv
// tinyrv_mc: multi-cycle RV32I integer-subset core (OP-IMM, OP, LUI, AUIPC,
// JAL, JALR, BRANCH) fetching over a req/ack instruction port.
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   imem_req/imem_addr    fetch request and address (== pc)
//   imem_ack/imem_rdata   fetch handshake and instruction word
//   pc                    current program counter
//   retire                one-cycle pulse per completed instruction
//   trap                  sticky fault flag, cleared only by reset
//   dbg_raddr/dbg_rdata   combinational debug read of the register file
module tinyrv_mc #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned NUM_REGS  = 32,
  parameter bit          BRANCH_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic        retire,
  output logic        trap,
  input  logic [4:0]  dbg_raddr,
  output logic [31:0] dbg_rdata
);

  localparam int unsigned AW = (NUM_REGS == 16) ? 4 : 5;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_TRAP  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        req_q, req_d;
  logic [31:0] regs_q [NUM_REGS];

  // Decode fields of the latched word
  logic [6:0]  opc;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_b, imm_u, imm_j;

  assign opc   = inst_q[6:0];
  assign rd    = inst_q[11:7];
  assign f3    = inst_q[14:12];
  assign rs1   = inst_q[19:15];
  assign rs2   = inst_q[24:20];
  assign f7    = inst_q[31:25];
  assign imm_i = {{20{inst_q[31]}}, inst_q[31:20]};
  assign imm_b = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
  assign imm_u = {inst_q[31:12], 12'b0};
  assign imm_j = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};

  logic        rd_ok, rs1_ok, rs2_ok, dbg_ok;
  logic [31:0] rs1_v, rs2_v;

  assign rd_ok  = {27'b0, rd} < NUM_REGS;
  assign rs1_ok = {27'b0, rs1} < NUM_REGS;
  assign rs2_ok = {27'b0, rs2} < NUM_REGS;
  assign dbg_ok = {27'b0, dbg_raddr} < NUM_REGS;

  assign rs1_v     = (rs1 == 5'd0 || !rs1_ok) ? '0 : regs_q[rs1[AW-1:0]];
  assign rs2_v     = (rs2 == 5'd0 || !rs2_ok) ? '0 : regs_q[rs2[AW-1:0]];
  assign dbg_rdata = (dbg_raddr == 5'd0 || !dbg_ok) ? '0 : regs_q[dbg_raddr[AW-1:0]];

  // Shared ALU for OP and OP-IMM; alt selects SUB/SRA(I)
  logic [31:0] alu_b, alu_y;
  logic        alu_alt;

  always_comb begin
    alu_b   = (opc == OPC_OP) ? rs2_v : imm_i;
    alu_alt = f7[5] && ((opc == OPC_OP && f3 == 3'b000) || f3 == 3'b101);
    alu_y   = '0;
    unique case (f3)
      3'b000: alu_y = alu_alt ? rs1_v - alu_b : rs1_v + alu_b;
      3'b001: alu_y = rs1_v << alu_b[4:0];
      3'b010: alu_y = {31'b0, $signed(rs1_v) < $signed(alu_b)};
      3'b011: alu_y = {31'b0, rs1_v < alu_b};
      3'b100: alu_y = rs1_v ^ alu_b;
      3'b101: alu_y = alu_alt ? $unsigned($signed(rs1_v) >>> alu_b[4:0]) : rs1_v >> alu_b[4:0];
      3'b110: alu_y = rs1_v | alu_b;
      3'b111: alu_y = rs1_v & alu_b;
      default: alu_y = '0;
    endcase
  end

  // Execute: result, next pc and fault for the latched word
  logic        illegal, use_rd, use_rs1, use_rs2, is_ctl, taken, fault;
  logic [31:0] wr_val, target, npc;

  always_comb begin
    illegal = 1'b0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    is_ctl  = 1'b0;
    taken   = 1'b0;
    wr_val  = '0;
    target  = '0;
    unique case (opc)
      OPC_OPIMM: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        wr_val  = alu_y;
        if (f3 == 3'b001 && f7 != 7'b0000000) illegal = 1'b1;
        if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000) illegal = 1'b1;
      end
      OPC_OP: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        wr_val  = alu_y;
        if (!(f7 == 7'b0000000 ||
              (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)))) illegal = 1'b1;
      end
      OPC_LUI: begin
        use_rd = 1'b1;
        wr_val = imm_u;
      end
      OPC_AUIPC: begin
        use_rd = 1'b1;
        wr_val = pc_q + imm_u;
      end
      OPC_JAL: begin
        use_rd = 1'b1;
        is_ctl = 1'b1;
        taken  = 1'b1;
        target = pc_q + imm_j;
        wr_val = pc_q + 32'd4;
      end
      OPC_JALR: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        is_ctl  = 1'b1;
        taken   = 1'b1;
        target  = (rs1_v + imm_i) & ~32'd1;
        wr_val  = pc_q + 32'd4;
        if (f3 != 3'b000) illegal = 1'b1;
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        is_ctl  = 1'b1;
        target  = pc_q + imm_b;
        unique case (f3)
          3'b000: taken = (rs1_v == rs2_v);
          3'b001: taken = (rs1_v != rs2_v);
          3'b100: taken = ($signed(rs1_v) < $signed(rs2_v));
          3'b101: taken = ($signed(rs1_v) >= $signed(rs2_v));
          3'b110: taken = (rs1_v < rs2_v);
          3'b111: taken = (rs1_v >= rs2_v);
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
    fault = illegal ||
            (use_rd && !rd_ok) || (use_rs1 && !rs1_ok) || (use_rs2 && !rs2_ok) ||
            (is_ctl && !BRANCH_EN) ||
            (taken && target[1:0] != 2'b00);
    npc = taken ? target : pc_q + 32'd4;
  end

  // Next-state logic; imem_req is registered so it stays low through reset
  // and rises on the first edge after release.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    unique case (state_q)
      ST_FETCH: begin
        if (req_q && imem_ack) begin
          inst_d  = imem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (fault) begin
          state_d = ST_TRAP;
        end else begin
          pc_d    = npc;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_TRAP;
    endcase
    req_d = (state_d == ST_FETCH);
  end

  logic wr_en;
  assign wr_en = (state_q == ST_EXEC) && !fault && use_rd && (rd != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      req_q   <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      req_q   <= req_d;
      if (wr_en) regs_q[rd[AW-1:0]] <= wr_val;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign retire    = (state_q == ST_EXEC) && !fault;
  assign trap      = (state_q == ST_TRAP);

endmodule

// File: tb/tb_tinyrv_mc.sv
module tb_tinyrv_mc;

  logic        clk = 1'b0;
  logic        rst_n, imem_ack, imem_req, retire, trap;
  logic [31:0] imem_rdata, imem_addr, pc, dbg_rdata;
  logic [4:0]  dbg_raddr;

  logic        rst16_n, ack16, req16, retire16, trap16;
  logic [31:0] rdata16, addr16, pc16, dbg16_rdata;
  logic [4:0]  dbg16_raddr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tinyrv_mc dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc), .retire(retire),
    .trap(trap), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  tinyrv_mc #(.NUM_REGS(16)) dut16 (
    .clk(clk), .rst_n(rst16_n), .imem_req(req16), .imem_addr(addr16),
    .imem_ack(ack16), .imem_rdata(rdata16), .pc(pc16), .retire(retire16),
    .trap(trap16), .dbg_raddr(dbg16_raddr), .dbg_rdata(dbg16_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] idx, input logic [31:0] exp);
    dbg_raddr = idx;
    #1;
    chk($sformatf("x%0d", idx), dbg_rdata, exp);
  endtask

  // Wait (bounded) for a request, then ack the word for one cycle.
  // Returns in the EXEC cycle of that instruction.
  task automatic issue(input logic [31:0] w);
    for (int n = 0; n < 30 && !imem_req; n++) step();
    chk("req_wait", {31'b0, imem_req}, 32'd1);
    imem_ack = 1'b1;
    imem_rdata = w;
    step();
    imem_ack = 1'b0;
    imem_rdata = '0;
  endtask

  task automatic ok_insn(input string tag, input logic [31:0] w, input logic [31:0] npc);
    issue(w);
    chk({tag, "_retire"}, {31'b0, retire}, 32'd1);
    step();
    chk({tag, "_retire_off"}, {31'b0, retire}, 32'd0);
    chk({tag, "_pc"}, pc, npc);
    chk({tag, "_req"}, {31'b0, imem_req}, 32'd1);
  endtask

  task automatic issue16(input logic [31:0] w);
    for (int n = 0; n < 30 && !req16; n++) step();
    chk("req16_wait", {31'b0, req16}, 32'd1);
    ack16 = 1'b1;
    rdata16 = w;
    step();
    ack16 = 1'b0;
    rdata16 = '0;
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; dbg_raddr = '0;
    rst16_n = 1'b0; ack16 = 1'b0; rdata16 = '0; dbg16_raddr = '0;
    step(); step();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_trap", {31'b0, trap}, 32'd0);
    chk("rst_retire", {31'b0, retire}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    rst_n = 1'b1;
    rst16_n = 1'b1;
    #1;
    chk("req_low_after_release", {31'b0, imem_req}, 32'd0);
    step();
    chk("req_first_edge", {31'b0, imem_req}, 32'd1);
    chk("addr0", imem_addr, 32'h0);

    // ADDI x1,x0,8 ; ADDI x0,x1,0
    ok_insn("addi_x1", 32'h0080_0093, 32'd4);
    rd(5'd1, 32'd8);
    ok_insn("addi_x0", 32'h0000_8013, 32'd8);
    rd(5'd0, 32'd0);

    // Ack withheld five cycles
    for (int n = 0; n < 5; n++) begin
      step();
      chk("stall_req", {31'b0, imem_req}, 32'd1);
      chk("stall_addr", imem_addr, 32'd8);
      chk("stall_retire", {31'b0, retire}, 32'd0);
    end
    ok_insn("addi_x2_8", 32'h0080_0113, 32'd12);

    // BEQ x1,x2,+16 taken at pc 12, then not taken at pc 32
    ok_insn("beq_taken", 32'h0020_8863, 32'd28);
    ok_insn("addi_x2_7", 32'h0070_0113, 32'd32);
    ok_insn("beq_not", 32'h0020_8863, 32'd36);

    // JAL x5,+0x100 at pc 36
    ok_insn("jal", 32'h1000_02EF, 32'h124);
    rd(5'd5, 32'h28);

    // ALU coverage
    ok_insn("addi_m1", 32'hFFF0_0193, 32'h128);
    rd(5'd3, 32'hFFFF_FFFF);
    ok_insn("srli", 32'h01C1_D213, 32'h12C);
    rd(5'd4, 32'h0000_000F);
    ok_insn("srai", 32'h4041_D313, 32'h130);
    rd(5'd6, 32'hFFFF_FFFF);
    ok_insn("sltu", 32'h0030_B3B3, 32'h134);
    rd(5'd7, 32'd1);
    ok_insn("slt", 32'h0030_A433, 32'h138);
    rd(5'd8, 32'd0);
    ok_insn("sub", 32'h4010_04B3, 32'h13C);
    rd(5'd9, 32'hFFFF_FFF8);
    ok_insn("lui", 32'h1234_5537, 32'h140);
    rd(5'd10, 32'h1234_5000);
    ok_insn("auipc", 32'h0000_1597, 32'h144);
    rd(5'd11, 32'h0000_1140);

    // JALR x0,x5,3 -> target 0x2A, misaligned -> trap
    issue(32'h0032_8067);
    chk("jalr_no_retire", {31'b0, retire}, 32'd0);
    imem_ack = 1'b1;
    imem_rdata = 32'h0080_0093;
    for (int n = 0; n < 20; n++) begin
      step();
      chk("trap_flag", {31'b0, trap}, 32'd1);
      chk("trap_req", {31'b0, imem_req}, 32'd0);
      chk("trap_retire", {31'b0, retire}, 32'd0);
      chk("trap_pc", pc, 32'h144);
    end
    imem_ack = 1'b0;

    // Reset while in TRAP
    rst_n = 1'b0;
    #1;
    chk("rst_trap_req", {31'b0, imem_req}, 32'd0);
    chk("rst_trap_trap", {31'b0, trap}, 32'd0);
    chk("rst_trap_pc", pc, 32'h0);
    rd(5'd1, 32'd0);
    rd(5'd5, 32'd0);
    step();
    rst_n = 1'b1;
    ok_insn("post_rst_addi", 32'h0080_0093, 32'd4);

    // Reset mid-FETCH, then a late ack while imem_req is low
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_fetch_req", {31'b0, imem_req}, 32'd0);
    chk("rst_fetch_pc", pc, 32'h0);
    rd(5'd1, 32'd0);
    imem_ack = 1'b1;
    imem_rdata = 32'h0050_0093;
    step();
    rst_n = 1'b1;
    step();
    imem_ack = 1'b0;
    chk("late_ack_retire", {31'b0, retire}, 32'd0);
    chk("late_ack_pc", pc, 32'h0);
    step();
    chk("late_ack_retire2", {31'b0, retire}, 32'd0);
    rd(5'd1, 32'd0);

    // Illegal word
    issue(32'hFFFF_FFFF);
    chk("ill_no_retire", {31'b0, retire}, 32'd0);
    step();
    chk("ill_trap", {31'b0, trap}, 32'd1);
    chk("ill_req", {31'b0, imem_req}, 32'd0);
    chk("ill_pc", pc, 32'h0);

    // RV32E instance: x15 legal, x20 traps
    issue16(32'h0030_0793);
    chk("e_retire", {31'b0, retire16}, 32'd1);
    step();
    chk("e_pc", pc16, 32'd4);
    dbg16_raddr = 5'd15;
    #1;
    chk("e_x15", dbg16_rdata, 32'd3);
    issue16(32'h0010_0A13);
    chk("e_x20_no_retire", {31'b0, retire16}, 32'd0);
    step();
    chk("e_x20_trap", {31'b0, trap16}, 32'd1);
    chk("e_x20_pc", pc16, 32'd4);
    dbg16_raddr = 5'd20;
    #1;
    chk("e_dbg_oob", dbg16_rdata, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
